// File: rtl/key_debounce.sv
// Push-button synchroniser/debouncer: clean level plus press, release and auto-repeat pulses.
// Optional auto-repeat is enabled by defining KEY_DEBOUNCE_AUTO_REPEAT_EN.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_PERIOD   = 5_000_000,
  parameter int unsigned CNT_W           = 26
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic event_pulse
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam bit               DB_ONE  = (DEBOUNCE_CYCLES == 1);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  state_t           state;
  logic             sync1;
  logic             sync2;
  logic             key_s;
  logic [CNT_W-1:0] db_cnt;
  logic             press_fire_c;
  logic             release_fire_c;
  logic             rep_fire_c;

  // Two-flop synchroniser; idles at "released"
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  assign key_s = ~sync2;

  // The cycle that first observes the new level counts as the first stable cycle
  assign press_fire_c   = key_s &&
                          ((state == RELEASED && DB_ONE) || (state == PRESS_CHK && db_cnt == DB_LAST));
  assign release_fire_c = !key_s &&
                          ((state == PRESSED && DB_ONE) || (state == RELEASE_CHK && db_cnt == DB_LAST));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= RELEASED;
      db_cnt        <= '0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      event_pulse   <= 1'b0;
    end else begin
      press_pulse   <= press_fire_c;
      release_pulse <= release_fire_c;
      event_pulse   <= press_fire_c | rep_fire_c;
      pressed       <= pressed ? !release_fire_c : press_fire_c;

      unique case (state)
        RELEASED: begin
          if (key_s) begin
            state  <= DB_ONE ? PRESSED : PRESS_CHK;
            db_cnt <= DB_ONE ? '0 : CNT_ONE;
          end
        end
        PRESS_CHK: begin
          if (!key_s) begin
            state  <= RELEASED;
            db_cnt <= '0;
          end else if (press_fire_c) begin
            state  <= PRESSED;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!key_s) begin
            state  <= DB_ONE ? RELEASED : RELEASE_CHK;
            db_cnt <= DB_ONE ? '0 : CNT_ONE;
          end
        end
        RELEASE_CHK: begin
          if (key_s) begin
            state  <= PRESSED;
            db_cnt <= '0;
          end else if (release_fire_c) begin
            state  <= RELEASED;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + CNT_ONE;
          end
        end
      endcase
    end
  end

`ifdef KEY_DEBOUNCE_AUTO_REPEAT_EN
  logic [CNT_W-1:0] rep_cnt;
  logic [CNT_W-1:0] rep_nxt_c;
  logic [CNT_W-1:0] rep_target_c;
  logic             rep_armed;
  logic             stay_pressed_c;
  logic             enter_pressed_c;

  // rep_cnt counts cycles in the current phase; first phase is REPEAT_DELAY, then REPEAT_PERIOD
  assign stay_pressed_c  = (state == PRESSED) && key_s;
  assign enter_pressed_c = press_fire_c || ((state == RELEASE_CHK) && key_s);
  assign rep_nxt_c       = rep_cnt + CNT_ONE;
  assign rep_target_c    = rep_armed ? CNT_W'(REPEAT_PERIOD) : CNT_W'(REPEAT_DELAY);
  assign rep_fire_c      = stay_pressed_c && (rep_nxt_c >= rep_target_c);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rep_cnt      <= '0;
      rep_armed    <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= rep_fire_c;
      if (stay_pressed_c) begin
        rep_cnt   <= rep_fire_c ? '0 : rep_nxt_c;
        rep_armed <= rep_armed | rep_fire_c;
      end else if (enter_pressed_c) begin
        rep_cnt   <= CNT_ONE;
        rep_armed <= 1'b0;
      end else begin
        rep_cnt   <= '0;
        rep_armed <= 1'b0;
      end
    end
  end
`else
  localparam int unsigned unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;

  assign rep_fire_c   = 1'b0;
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with a window-based behavioural model checked every cycle.
module tb_key_debounce;

  localparam int unsigned DB  = 4;
  localparam int unsigned DLY = 10;
  localparam int unsigned PER = 3;
`ifdef KEY_DEBOUNCE_AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk;
  logic reset_n;
  logic key_n;
  logic pressed;
  logic press_pulse;
  logic release_pulse;
  logic repeat_pulse;
  logic event_pulse;

  key_debounce #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (DLY),
    .REPEAT_PERIOD  (PER),
    .CNT_W          (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .key_n        (key_n),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse),
    .event_pulse  (event_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  task automatic chk_b(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: every raw sample since reset; the debouncer acts on the sample taken two edges earlier.
  bit samp[$];
  bit m_acc, m_press, m_rel, m_rep, m_flip, m_inp;
  int m_run, m_t;

  function automatic bit seen(input int idx);
    if (idx < 0) return 1'b1;
    return samp[idx];
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      samp.delete();
      m_acc = 0; m_press = 0; m_rel = 0; m_rep = 0; m_run = 0;
    end else begin
      samp.push_back(key_n);
      m_t    = samp.size() - 1;
      // Level is accepted once the last DB observed samples all disagree with it
      m_flip = 1'b1;
      for (int k = 0; k < int'(DB); k++)
        if (seen(m_t - 2 - k) != m_acc) m_flip = 1'b0;
      m_press = m_flip && !m_acc;
      m_rel   = m_flip && m_acc;
      if (m_flip) m_acc = !m_acc;
      m_inp = m_acc && (seen(m_t - 2) == 1'b0);
      m_run = m_inp ? m_run + 1 : 0;
      m_rep = AUTO && m_inp && (m_run >= int'(DLY)) && (((m_run - int'(DLY)) % int'(PER)) == 0);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle compare plus pulse bookkeeping for the directed checks
  int n_press = 0, n_rel = 0, n_rep = 0, n_evt = 0;
  int rep_first = -1, rep_second = -1;

  always @(negedge clk) begin
    if (chk_en) begin
      chk_b("pressed", pressed, m_acc);
      chk_b("press_pulse", press_pulse, m_press);
      chk_b("release_pulse", release_pulse, m_rel);
      chk_b("repeat_pulse", repeat_pulse, m_rep);
      chk_b("event_pulse", event_pulse, m_press | m_rep);
    end
    if (press_pulse) n_press++;
    if (release_pulse) n_rel++;
    if (event_pulse) n_evt++;
    if (repeat_pulse) begin
      n_rep++;
      if (rep_first < 0) rep_first = cyc;
      else if (rep_second < 0) rep_second = cyc;
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk_b({tag, "_pressed"}, pressed, 1'b0);
    chk_b({tag, "_press"}, press_pulse, 1'b0);
    chk_b({tag, "_release"}, release_pulse, 1'b0);
    chk_b({tag, "_repeat"}, repeat_pulse, 1'b0);
    chk_b({tag, "_event"}, event_pulse, 1'b0);
  endtask

  int p, b_press, b_rel, b_rep, b_evt;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1;
    key_n   = 1'b1;
    #1 reset_n = 1'b0;
    #1 chk_all_zero("reset");
    chk_en = 1'b1;
    edges(2);
    reset_n = 1'b1;

    // Idle released
    edges(20);
    chk_i("idle_presses", n_press, 0);
    chk_b("idle_pressed", pressed, 1'b0);

    // Clean press: pulse on the 6th edge counting the first low sample
    b_press = n_press; b_rep = n_rep; b_evt = n_evt;
    rep_first = -1; rep_second = -1;
    key_n = 1'b0;
    edges(5);
    chk_b("press_e4_pulse", press_pulse, 1'b0);
    chk_b("press_e4_level", pressed, 1'b0);
    edges(1);
    chk_b("press_e5_pulse", press_pulse, 1'b1);
    chk_b("press_e5_event", event_pulse, 1'b1);
    chk_b("press_e5_level", pressed, 1'b1);
    p = cyc;
    edges(1);
    chk_b("press_e6_pulse", press_pulse, 1'b0);
    chk_b("press_e6_level", pressed, 1'b1);
    edges(29);

    // Clean release, symmetric latency
    b_rel = n_rel;
    key_n = 1'b1;
    edges(5);
    chk_b("release_r4_pulse", release_pulse, 1'b0);
    chk_b("release_r4_level", pressed, 1'b1);
    edges(1);
    chk_b("release_r5_pulse", release_pulse, 1'b1);
    chk_b("release_r5_level", pressed, 1'b0);
    edges(2);
    chk_i("hold_presses", n_press - b_press, 1);
    chk_i("hold_releases", n_rel - b_rel, 1);
    chk_i("hold_repeats", n_rep - b_rep, AUTO ? 8 : 0);
    chk_i("hold_events", n_evt - b_evt, AUTO ? 9 : 1);
    chk_i("first_repeat", rep_first, AUTO ? p + 9 : -1);
    chk_i("second_repeat", rep_second, AUTO ? p + 12 : -1);

    // Bounce while released
    b_press = n_press;
    key_n = 1'b0; edges(3);
    key_n = 1'b1; edges(1);
    key_n = 1'b0; edges(3);
    key_n = 1'b1; edges(10);
    chk_i("bounce_rel_presses", n_press - b_press, 0);
    chk_b("bounce_rel_level", pressed, 1'b0);

    // Bounce while pressed
    b_press = n_press; b_rel = n_rel;
    key_n = 1'b0; edges(8);
    key_n = 1'b1; edges(3);
    key_n = 1'b0; edges(1);
    key_n = 1'b1; edges(3);
    key_n = 1'b0; edges(8);
    chk_i("bounce_prs_presses", n_press - b_press, 1);
    chk_i("bounce_prs_releases", n_rel - b_rel, 0);
    chk_b("bounce_prs_level", pressed, 1'b1);
    key_n = 1'b1; edges(8);
    chk_i("bounce_prs_release_after", n_rel - b_rel, 1);

    // Reset pulse mid-debounce, key kept held
    key_n = 1'b0;
    edges(4);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("async_rst");
    #2 reset_n = 1'b1;
    edges(5);
    chk_b("rst_f4_pulse", press_pulse, 1'b0);
    edges(1);
    chk_b("rst_f5_pulse", press_pulse, 1'b1);
    chk_b("rst_f5_level", pressed, 1'b1);
    key_n = 1'b1; edges(8);
    chk_b("rst_released", pressed, 1'b0);

    // Key held across reset deassertion
    b_press = n_press; b_rel = n_rel;
    key_n = 1'b0;
    #1 reset_n = 1'b0;
    edges(3);
    #3 reset_n = 1'b1;
    edges(5);
    chk_b("held_f4_pulse", press_pulse, 1'b0);
    edges(1);
    chk_b("held_f5_pulse", press_pulse, 1'b1);
    edges(10);
    chk_i("held_presses", n_press - b_press, 1);
    chk_i("held_releases", n_rel - b_rel, 0);
    key_n = 1'b1; edges(8);
    chk_i("held_release_after", n_rel - b_rel, 1);

    edges(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
